// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Shared widths and FSM state encoding for the instruction
//                memory loader. Default widths match the processor core.
//  Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Default instruction address width (memory depth = 2**c_pc_width)
    localparam int c_pc_width   = 4;
    // Default instruction word width: opcode in the top bits, immediate below
    localparam int c_rom_width  = 12;
    // Input stream byte width; also the bit position where the opcode starts
    localparam int c_byte_width = 8;

    // Loader states, explicitly 3-bit encoded
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_FILL  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Byte-stream loader for the instruction memory. Reads a word
//                count, then high/low byte pairs forming {opcode, immediate},
//                writes them from address 0 upward and zero-fills the rest of
//                the memory. CPU_HOLD keeps the core in reset while loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int PC_WIDTH   = c_pc_width,
    parameter int ROM_WIDTH  = c_rom_width,
    parameter int BYTE_WIDTH = c_byte_width
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [BYTE_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic                  WR_EN,
    output logic [PC_WIDTH-1:0]   WR_ADDR,
    output logic [ROM_WIDTH-1:0]  WR_DATA,
    output logic                  CPU_HOLD,
    output logic                  DONE,
    output logic                  ERR
);

    // Opcode width: whatever part of the word the low byte does not cover
    localparam int c_opc_width = ROM_WIDTH - BYTE_WIDTH;
    // Counter width must hold both a raw count byte and the full depth
    localparam int c_cnt_width = (PC_WIDTH > BYTE_WIDTH) ? PC_WIDTH + 1 : BYTE_WIDTH + 1;
    localparam logic [c_cnt_width-1:0] c_depth     = c_cnt_width'(1) << PC_WIDTH;
    localparam logic [c_cnt_width-1:0] c_cnt_one   = c_cnt_width'(1);
    localparam logic [PC_WIDTH-1:0]    c_last_addr = {PC_WIDTH{1'b1}};

    state_t                   r_state;
    state_t                   w_state_next;

    logic                     w_xfer;
    logic                     w_start_ok;
    logic                     w_opc_bad;
    logic                     w_wr_fire;
    logic [ROM_WIDTH-1:0]     w_wr_word;
    logic [c_cnt_width-1:0]   w_count_n;
    logic [c_cnt_width-1:0]   w_words_inc;

    logic [c_cnt_width-1:0]   r_n;
    logic [c_cnt_width-1:0]   r_words;
    logic [PC_WIDTH-1:0]      r_addr;
    logic [c_opc_width-1:0]   r_opcode;
    logic                     r_wr_en;
    logic [PC_WIDTH-1:0]      r_wr_addr;
    logic [ROM_WIDTH-1:0]     r_wr_data;

    // A count byte of zero stands for a full-depth load
    assign w_count_n   = (IN_DATA == '0) ? c_depth : c_cnt_width'(IN_DATA);
    // The high byte may only carry opcode bits; anything above is malformed
    assign w_opc_bad   = |IN_DATA[BYTE_WIDTH-1:c_opc_width];
    assign w_words_inc = r_words + c_cnt_one;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived status outputs
    always_comb begin
        w_state_next = r_state;
        IN_READY     = 1'b0;
        CPU_HOLD     = 1'b1;
        DONE         = 1'b0;
        ERR          = 1'b0;
        w_xfer       = 1'b0;
        w_start_ok   = 1'b0;
        w_wr_fire    = 1'b0;
        w_wr_word    = '0;

        unique case (r_state)
            S_IDLE: begin
                CPU_HOLD   = 1'b0;
                w_start_ok = START;
                if (START) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                IN_READY = 1'b1;
                w_xfer   = IN_VALID;
                if (IN_VALID) begin
                    w_state_next = (w_count_n > c_depth) ? S_ERROR : S_HI;
                end
            end
            S_HI: begin
                IN_READY = 1'b1;
                w_xfer   = IN_VALID;
                if (IN_VALID) begin
                    w_state_next = w_opc_bad ? S_ERROR : S_LO;
                end
            end
            S_LO: begin
                IN_READY  = 1'b1;
                w_xfer    = IN_VALID;
                w_wr_fire = IN_VALID;
                w_wr_word = {r_opcode, IN_DATA};
                if (IN_VALID) begin
                    if (w_words_inc < r_n) begin
                        w_state_next = S_HI;
                    end else if (r_addr != c_last_addr) begin
                        w_state_next = S_FILL;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_FILL: begin
                w_wr_fire = 1'b1;
                if (r_addr == c_last_addr) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                DONE         = 1'b1;
                w_state_next = S_IDLE;
            end
            S_ERROR: begin
                ERR        = 1'b1;
                w_start_ok = START;
                if (START) begin
                    w_state_next = S_COUNT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Count/opcode capture, address counter and registered write port
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_n       <= '0;
            r_words   <= '0;
            r_addr    <= '0;
            r_opcode  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_fire;
            if (w_start_ok) begin
                r_addr  <= '0;
                r_words <= '0;
            end
            if (r_state == S_COUNT && w_xfer) begin
                r_n     <= w_count_n;
                r_words <= '0;
                r_addr  <= '0;
            end
            if (r_state == S_HI && w_xfer) begin
                r_opcode <= IN_DATA[c_opc_width-1:0];
            end
            if (r_state == S_LO && w_xfer) begin
                r_words <= w_words_inc;
            end
            if (w_wr_fire) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_wr_word;
                r_addr    <= r_addr + 1'b1;
            end
        end
    end

    assign WR_EN   = r_wr_en;
    assign WR_ADDR = r_wr_addr;
    assign WR_DATA = r_wr_data;

endmodule : program_loader
`default_nettype wire
